// File: rtl/prog_counter_pkg.sv
// ---------------------------------------------------------------------------
// prog_counter_pkg
// Shared types and defaults for the programmable up/down counter.
//   dir_e       : count direction (maps the up_dn input bit)
//   lim_mode_e  : boundary behaviour (maps the sat_en input bit)
//   DEFAULT_*   : default parameter values used by the counter modules
// ---------------------------------------------------------------------------
package prog_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } lim_mode_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : prog_counter_pkg

// File: rtl/prog_counter_next.sv
// ---------------------------------------------------------------------------
// prog_counter_next
// Purely combinational step calculator for prog_counter. Given the current
// count, the modulus and the direction/mode controls it returns the value the
// counter would take on an enabled step.
// Ports:
//   out      in  WIDTH  current count
//   modulus  in  WIDTH  inclusive upper limit
//   up_dn    in  1      1 = count up, 0 = count down
//   sat_en   in  1      1 = saturate at the boundary, 0 = wrap
//   next_val out WIDTH  count after an enabled step
//   boundary out 1      current count sits on the limit for this direction
//   wrap_evt out 1      an enabled step from here is a wrap step
// ---------------------------------------------------------------------------
module prog_counter_next
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] modulus,
    input  logic             up_dn,
    input  logic             sat_en,
    output logic [WIDTH-1:0] next_val,
    output logic             boundary,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    dir_e      dir;
    lim_mode_e mode;

    assign dir  = dir_e'(up_dn);
    assign mode = lim_mode_e'(sat_en);

    always_comb begin
        // ">=" rather than "==" so a count left above a freshly lowered
        // modulus (or loaded above it) still counts as being at the limit.
        if (dir == DIR_UP) begin
            boundary = (out >= modulus);
        end else begin
            boundary = (out == '0);
        end

        wrap_evt = boundary && (mode == MODE_WRAP);

        next_val = out;
        if (!boundary) begin
            // Off the boundary the +/-1 can never cross 0 or all-ones:
            // up implies out < modulus <= max, down implies out > 0.
            if (dir == DIR_UP) begin
                next_val = out + ONE;
            end else begin
                next_val = out - ONE;
            end
        end else if (mode == MODE_WRAP) begin
            next_val = (dir == DIR_UP) ? '0 : modulus;
        end else begin
            // Saturate: hold, except an up count stranded above the
            // modulus is pulled back down onto it.
            if ((dir == DIR_UP) && (out > modulus)) begin
                next_val = modulus;
            end
        end
    end

endmodule : prog_counter_next

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
// Loadable up/down counter with programmable modulus, wrap or saturate
// behaviour at the limit, a one-cycle wrap pulse and a sticky overflow flag.
// Edge priority: clr > load > enable > hold.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-low reset
//   data     in  WIDTH  value captured on load
//   load     in  1      synchronous load of data (taken verbatim)
//   enable   in  1      count step enable
//   up_dn    in  1      1 = up, 0 = down
//   modulus  in  WIDTH  inclusive upper limit, sampled every cycle
//   sat_en   in  1      1 = saturate, 0 = wrap
//   clr      in  1      synchronous clear to RST_VAL (also clears ovf)
//   ovf_clr  in  1      synchronous clear of ovf (a same-edge set wins)
//   out      out WIDTH  registered count
//   wrap_p   out 1      registered pulse, high the cycle after a wrap step
//   at_lim   out 1      combinational: out is at the limit for up_dn
//   ovf      out 1      sticky flag, set by any enabled boundary step
// ---------------------------------------------------------------------------
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] modulus,
    input  logic             sat_en,
    input  logic             clr,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             wrap_p,
    output logic             at_lim,
    output logic             ovf
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             wrap_p_reg;
    logic             wrap_p_next;
    logic             ovf_reg;
    logic             ovf_next;

    logic [WIDTH-1:0] step_val;
    logic             boundary;
    logic             wrap_evt;
    logic             step_taken;

    prog_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .out      (out_reg),
        .modulus  (modulus),
        .up_dn    (up_dn),
        .sat_en   (sat_en),
        .next_val (step_val),
        .boundary (boundary),
        .wrap_evt (wrap_evt)
    );

    // A step only happens when neither clear nor load claims the edge.
    assign step_taken = enable && !clr && !load;

    always_comb begin
        out_next    = out_reg;
        wrap_p_next = 1'b0;

        if (clr) begin
            out_next = RST_VAL;
        end else if (load) begin
            out_next = data;
        end else if (enable) begin
            out_next    = step_val;
            wrap_p_next = wrap_evt;
        end
    end

    // Overflow: clr dominates, then a boundary step sets, then ovf_clr.
    always_comb begin
        ovf_next = ovf_reg;
        if (clr) begin
            ovf_next = 1'b0;
        end else if (step_taken && boundary) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg    <= RST_VAL;
            wrap_p_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            out_reg    <= out_next;
            wrap_p_reg <= wrap_p_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign out    = out_reg;
    assign wrap_p = wrap_p_reg;
    assign ovf    = ovf_reg;
    assign at_lim = boundary;

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_counter
// Scoreboard bench for prog_counter (WIDTH=5, RST_VAL=0). Each scenario task
// pushes the expected {out, wrap_p, ovf, at_lim} for a cycle, advances the
// clock, pops and compares.
// ---------------------------------------------------------------------------
module tb_prog_counter;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] out;
        logic         wrap_p;
        logic         ovf;
        logic         at_lim;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] data;
    logic         load;
    logic         enable;
    logic         up_dn;
    logic [W-1:0] modulus;
    logic         sat_en;
    logic         clr;
    logic         ovf_clr;
    logic [W-1:0] out;
    logic         wrap_p;
    logic         at_lim;
    logic         ovf;

    exp_t sb_q[$];
    exp_t e;
    exp_t got;
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_counter #(
        .WIDTH   (W),
        .RST_VAL ('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .load    (load),
        .enable  (enable),
        .up_dn   (up_dn),
        .modulus (modulus),
        .sat_en  (sat_en),
        .clr     (clr),
        .ovf_clr (ovf_clr),
        .out     (out),
        .wrap_p  (wrap_p),
        .at_lim  (at_lim),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] o, input logic w, input logic v, input logic a);
        exp_t x;
        x.out    = o;
        x.wrap_p = w;
        x.ovf    = v;
        x.at_lim = a;
        sb_q.push_back(x);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; data = '0; load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        modulus = 5'd31; sat_en = 1'b0; clr = 1'b0; ovf_clr = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            push(5'd0, 1'b0, 1'b0, 1'b0);
            if (k > 0) tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("reset_hold[%0d] out=%0d ok", k, out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        for (int k = 1; k <= 33; k++) begin
            push(5'(k % 32), (k == 32), (k >= 32), ((k % 32) == 31));
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL count_up[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("count_up[%0d] out=%0d wrap_p=%b ok", k, out, wrap_p);
        end
    endtask

    task automatic test_mod6_down();
        logic [W-1:0] seq_o [6] = '{5'd3, 5'd2, 5'd1, 5'd0, 5'd5, 5'd4};
        logic         seq_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; data = 5'd3; enable = 1'b0; up_dn = 1'b0; modulus = 5'd5;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin load = 1'b0; enable = 1'b1; end
            push(seq_o[k], seq_w[k], 1'b1, (seq_o[k] == 5'd0));
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mod6_down[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("mod6_down[%0d] out=%0d wrap_p=%b ok", k, out, wrap_p);
        end
    endtask

    task automatic test_saturate();
        // clear, load 20 over modulus 10, then clamp to 10 and hold
        clr = 1'b1; enable = 1'b0; up_dn = 1'b1; modulus = 5'd10; sat_en = 1'b1;
        push(5'd0, 1'b0, 1'b0, 1'b0);
        push(5'd20, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) push(5'd10, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin clr = 1'b0; load = 1'b1; data = 5'd20; enable = 1'b1; end
            if (k == 2) load = 1'b0;
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL saturate[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("saturate[%0d] out=%0d ok", k, out);
        end
        enable = 1'b0;
    endtask

    task automatic test_priority();
        push(5'd4, 1'b0, 1'b1, 1'b0);
        push(5'd0, 1'b0, 1'b0, 1'b0);
        push(5'd7, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin load = 1'b1; data = 5'd4; enable = 1'b0; end
                1: begin clr = 1'b1; load = 1'b1; data = 5'd7; enable = 1'b1; end
                default: begin clr = 1'b0; load = 1'b1; data = 5'd7; enable = 1'b1; end
            endcase
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("priority[%0d] out=%0d ovf=%b ok", k, out, ovf);
        end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_sticky_ovf();
        // out=7, modulus=7, wrap mode: step wraps; reload; wrap+ovf_clr; ovf_clr alone
        sat_en = 1'b0; modulus = 5'd7; up_dn = 1'b1;
        push(5'd0, 1'b1, 1'b1, 1'b0);
        push(5'd7, 1'b0, 1'b1, 1'b1);
        push(5'd0, 1'b1, 1'b1, 1'b0);
        push(5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin enable = 1'b1; load = 1'b0; ovf_clr = 1'b0; end
                1: begin enable = 1'b0; load = 1'b1; data = 5'd7; end
                2: begin enable = 1'b1; load = 1'b0; ovf_clr = 1'b1; end
                default: begin enable = 1'b0; ovf_clr = 1'b1; end
            endcase
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL sticky_ovf[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("sticky_ovf[%0d] ovf=%b ok", k, ovf);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_modulus_edges();
        // modulus 0 wrap (up, up, down), modulus 0 saturate, then lowered modulus
        modulus = 5'd0; sat_en = 1'b0; up_dn = 1'b1; enable = 1'b1;
        push(5'd0, 1'b1, 1'b1, 1'b1);
        push(5'd0, 1'b1, 1'b1, 1'b1);
        push(5'd0, 1'b1, 1'b1, 1'b1);
        push(5'd0, 1'b0, 1'b1, 1'b1);
        push(5'd20, 1'b0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            case (k)
                2: up_dn = 1'b0;
                3: sat_en = 1'b1;
                4: begin sat_en = 1'b0; up_dn = 1'b1; modulus = 5'd31;
                         enable = 1'b0; load = 1'b1; data = 5'd20; end
                5: begin load = 1'b0; enable = 1'b1; modulus = 5'd12; end
                default: ;
            endcase
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL modulus_edges[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("modulus_edges[%0d] out=%0d wrap_p=%b ok", k, out, wrap_p);
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        // direction flipped on consecutive edges with no idle cycle
        logic [W-1:0] seq_o [5] = '{5'd5, 5'd6, 5'd7, 5'd6, 5'd5};
        logic         seq_d [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        modulus = 5'd31;
        for (int k = 0; k < 5; k++) begin
            load = (k == 0); data = 5'd5; enable = (k != 0); up_dn = seq_d[k];
            push(seq_o[k], 1'b0, 1'b1, 1'b0);
            tick();
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("back_to_back[%0d] out=%0d ok", k, out);
        end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_async_reset();
        // down wrap from 0 to modulus 17 gives out=17 with wrap_p high
        up_dn = 1'b0; modulus = 5'd17; sat_en = 1'b0;
        push(5'd0, 1'b0, 1'b1, 1'b1);
        push(5'd17, 1'b1, 1'b1, 1'b0);
        push(5'd0, 1'b0, 1'b0, 1'b1);
        push(5'd0, 1'b0, 1'b0, 1'b1);
        push(5'd17, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin load = 1'b1; data = 5'd0; enable = 1'b0; end
                1: begin load = 1'b0; enable = 1'b1; end
                default: ;
            endcase
            if (k == 2) begin
                #3 rst = 1'b0;   // between edges, no clock edge follows before the check
                #1;
            end else if (k == 3) begin
                tick();
            end else if (k == 4) begin
                @(negedge clk);
                rst = 1'b1;
                tick();
            end else begin
                tick();
            end
            e = sb_q.pop_front();
            got = {out, wrap_p, ovf, at_lim};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: out=%0d wrap_p=%b ovf=%b at_lim=%b, want out=%0d wrap_p=%b ovf=%b at_lim=%b",
                         k, out, wrap_p, ovf, at_lim, e.out, e.wrap_p, e.ovf, e.at_lim);
            end else $display("async_reset[%0d] out=%0d wrap_p=%b ovf=%b ok", k, out, wrap_p, ovf);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_mod6_down();
        test_saturate();
        test_priority();
        test_sticky_ovf();
        test_modulus_edges();
        test_back_to_back();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_counter
